// File: rtl/i2s_capture_array.sv
// Multi-line I2S receiver: N_MICS data lines share one SCK/WS pair, and each
// complete left+right period is published as one packed frame on valid/ready.
module i2s_capture_array #(
  parameter int N_MICS      = 2,
  parameter int SAMPLE_W    = 24,
  parameter int SLOT_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           enable_i,
  input  logic                           sck_i,
  input  logic                           ws_i,
  input  logic [N_MICS-1:0]              sd_i,
  output logic [2*N_MICS*SAMPLE_W-1:0]   data_o,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic                           overflow_o,
  output logic                           frame_err_o,
  output logic                           ovf_sticky_o,
  input  logic                           clr_i
);

  localparam int CNT_W = $clog2(SLOT_W + 1);
  localparam logic [CNT_W-1:0] SAMPLE_CNT = CNT_W'(SAMPLE_W);
  localparam logic [CNT_W-1:0] SLOT_CNT   = CNT_W'(SLOT_W);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LEFT  = 2'd1;
  localparam logic [1:0] S_RIGHT = 2'd2;

  logic [SYNC_STAGES-1:0]             r_sck_sync;
  logic [SYNC_STAGES-1:0]             r_ws_sync;
  logic [SYNC_STAGES-1:0][N_MICS-1:0] r_sd_sync;
  logic                               r_sck_prev;
  logic                               r_ws_last;
  logic [CNT_W-1:0]                   r_bit_cnt;
  logic [1:0]                         r_state;
  logic [N_MICS-1:0][SAMPLE_W-1:0]    r_left;
  logic [N_MICS-1:0][SAMPLE_W-1:0]    r_right;
  logic [2*N_MICS*SAMPLE_W-1:0]       r_data;
  logic                               r_valid;
  logic                               r_overflow;
  logic                               r_frame_err;
  logic                               r_ovf_sticky;

  logic                               w_rise;
  logic                               w_ws_s;
  logic [N_MICS-1:0]                  w_sd_s;
  logic                               w_boundary;
  logic                               w_short;
  logic                               w_shift;
  logic                               w_publish;
  logic                               w_accept;
  logic                               w_load;
  logic                               w_drop;
  logic                               w_ferr;
  logic [2*N_MICS*SAMPLE_W-1:0]       w_frame;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sck_sync <= '0;
      r_ws_sync  <= '0;
      r_sd_sync  <= '0;
      r_sck_prev <= 1'b0;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], sck_i};
      r_ws_sync  <= {r_ws_sync[SYNC_STAGES-2:0], ws_i};
      r_sd_sync  <= {r_sd_sync[SYNC_STAGES-2:0], sd_i};
      r_sck_prev <= r_sck_sync[SYNC_STAGES-1];
    end
  end

  // WS and SD are taken from the same synchroniser depth as SCK so they stay aligned.
  assign w_rise     = r_sck_sync[SYNC_STAGES-1] & ~r_sck_prev;
  assign w_ws_s     = r_ws_sync[SYNC_STAGES-1];
  assign w_sd_s     = r_sd_sync[SYNC_STAGES-1];
  assign w_boundary = w_rise & (w_ws_s != r_ws_last);
  assign w_short    = (r_bit_cnt < SAMPLE_CNT);
  assign w_shift    = w_rise & ~w_boundary & w_short;

  assign w_publish = enable_i & w_boundary & (r_state == S_RIGHT) & ~w_ws_s & ~w_short;
  assign w_accept  = r_valid & ready_i;
  assign w_load    = w_publish & (~r_valid | w_accept);
  assign w_drop    = w_publish & ~w_load;
  assign w_ferr    = enable_i & w_boundary & (r_state != S_IDLE) & w_short;

  genvar gi;
  generate
    for (gi = 0; gi < N_MICS; gi++) begin : g_line
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_left[gi]  <= '0;
          r_right[gi] <= '0;
        end else if (w_shift) begin
          if (w_ws_s) r_right[gi] <= SAMPLE_W'({r_right[gi], w_sd_s[gi]});
          else        r_left[gi]  <= SAMPLE_W'({r_left[gi], w_sd_s[gi]});
        end
      end

      assign w_frame[(2*gi)*SAMPLE_W   +: SAMPLE_W] = r_left[gi];
      assign w_frame[(2*gi+1)*SAMPLE_W +: SAMPLE_W] = r_right[gi];
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ws_last    <= 1'b0;
      r_bit_cnt    <= '0;
      r_state      <= S_IDLE;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_overflow   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_ovf_sticky <= 1'b0;
    end else begin
      r_overflow  <= w_drop;
      r_frame_err <= w_ferr;

      if (w_rise) begin
        r_ws_last <= w_ws_s;
        if (w_boundary)            r_bit_cnt <= '0;
        else if (r_bit_cnt < SLOT_CNT) r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end

      // A short slot restarts at LEFT only if the new slot is itself a left slot.
      if (!enable_i) begin
        r_state <= S_IDLE;
      end else if (w_boundary) begin
        case (r_state)
          S_IDLE:  if (!w_ws_s) r_state <= S_LEFT;
          S_LEFT:  if (w_short) r_state <= w_ws_s ? S_IDLE : S_LEFT;
                   else if (w_ws_s) r_state <= S_RIGHT;
          S_RIGHT: if (w_short) r_state <= w_ws_s ? S_IDLE : S_LEFT;
                   else if (!w_ws_s) r_state <= S_LEFT;
          default: r_state <= S_IDLE;
        endcase
      end

      if (w_load) begin
        r_data  <= w_frame;
        r_valid <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end

      if (clr_i)       r_ovf_sticky <= 1'b0;
      else if (w_drop) r_ovf_sticky <= 1'b1;
    end
  end

  assign data_o       = r_data;
  assign valid_o      = r_valid;
  assign overflow_o   = r_overflow;
  assign frame_err_o  = r_frame_err;
  assign ovf_sticky_o = r_ovf_sticky;

endmodule

// File: tb/tb_i2s_capture_array.sv
// Directed bench for i2s_capture_array: bit-level I2S stimulus on two lines,
// one task per scenario, monitor records handshakes and pulses.
module tb_i2s_capture_array;
  localparam int N    = 2;
  localparam int W    = 24;
  localparam int SLOT = 32;
  localparam int FW   = 2 * N * W;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          enable_i = 1'b0;
  logic          sck_i = 1'b0;
  logic          ws_i = 1'b0;
  logic [N-1:0]  sd_i = '0;
  logic [FW-1:0] data_o;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic          overflow_o;
  logic          frame_err_o;
  logic          ovf_sticky_o;
  logic          clr_i = 1'b0;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int ovf_cnt = 0;
  int ferr_cnt = 0;
  logic [FW-1:0] cap [0:63];

  always #5 clk = ~clk;

  i2s_capture_array #(.N_MICS(N), .SAMPLE_W(W), .SLOT_W(SLOT), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .sck_i(sck_i), .ws_i(ws_i),
    .sd_i(sd_i), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .overflow_o(overflow_o), .frame_err_o(frame_err_o), .ovf_sticky_o(ovf_sticky_o),
    .clr_i(clr_i)
  );

  // Handshakes and pulses are observed mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (valid_o && ready_i) begin
      cap[hs_cnt[5:0]] <= data_o;
      hs_cnt <= hs_cnt + 1;
    end
    if (overflow_o)  ovf_cnt  <= ovf_cnt + 1;
    if (frame_err_o) ferr_cnt <= ferr_cnt + 1;
  end

  function automatic logic [FW-1:0] pack(input logic [W-1:0] l0, r0, l1, r1);
    return {r1, l1, r0, l0};
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic ws, input logic [N-1:0] sd);
    sck_i = 1'b0; ws_i = ws; sd_i = sd;
    wait_clks(4);
    sck_i = 1'b1;
    wait_clks(4);
  endtask

  // Bit 0 of a slot is the previous slot's LSB; bits 1..W carry the sample MSB first.
  task automatic send_slot(input logic ws, input logic [W-1:0] d0, d1, input int nbits);
    logic [N-1:0] sd;
    for (int b = 0; b < nbits; b++) begin
      sd = '0;
      if (b >= 1 && b <= W) sd = {d1[W-b], d0[W-b]};
      drive_bit(ws, sd);
    end
  endtask

  task automatic send_frame(input logic [W-1:0] l0, r0, l1, r1);
    send_slot(1'b0, l0, l1, SLOT);
    send_slot(1'b1, r0, r1, SLOT);
  endtask

  task automatic start_stream();
    enable_i = 1'b1;
    drive_bit(1'b1, '0);
    drive_bit(1'b1, '0);
  endtask

  task automatic tail_bit();
    drive_bit(1'b0, '0);
    wait_clks(2);
  endtask

  task automatic stop_stream();
    enable_i = 1'b0;
    wait_clks(4);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    wait_clks(3);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
    checks++; if (data_o !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", data_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow_o); end
    checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", frame_err_o); end
    checks++; if (ovf_sticky_o !== 1'b0) begin errors++; $display("FAIL reset_sticky: got %b expected 0", ovf_sticky_o); end
    rst_i = 1'b0;
    wait_clks(2);
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [FW-1:0] exp_f;
    int hs0, fe0;
    exp_f = 96'h800000_7FFFFF_ABCDEF_123456;
    hs0 = hs_cnt; fe0 = ferr_cnt;
    ready_i = 1'b0;
    start_stream();
    send_frame(24'h123456, 24'hABCDEF, 24'h7FFFFF, 24'h800000);
    tail_bit();
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", valid_o); end
    checks++; if (data_o !== exp_f) begin errors++; $display("FAIL basic_data: got %h expected %h", data_o, exp_f); end
    checks++; if (hs_cnt - hs0 != 0) begin errors++; $display("FAIL basic_no_hs: got %0d expected 0", hs_cnt - hs0); end
    checks++; if (ferr_cnt - fe0 != 0) begin errors++; $display("FAIL basic_ferr: got %0d expected 0", ferr_cnt - fe0); end
    ready_i = 1'b1;
    wait_clks(1);
    ready_i = 1'b0;
    checks++; if (hs_cnt - hs0 != 1) begin errors++; $display("FAIL basic_hs: got %0d expected 1", hs_cnt - hs0); end
    checks++; if (cap[hs0[5:0]] !== exp_f) begin errors++; $display("FAIL basic_cap: got %h expected %h", cap[hs0[5:0]], exp_f); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL basic_valid_fall: got %b expected 0", valid_o); end
    stop_stream();
    $display("test_basic done");
  endtask

  task automatic test_overflow();
    logic [FW-1:0] exp_a;
    int hs0, ov0;
    exp_a = pack(24'h111111, 24'h222222, 24'h333333, 24'h444444);
    hs0 = hs_cnt; ov0 = ovf_cnt;
    ready_i = 1'b0;
    start_stream();
    send_frame(24'h111111, 24'h222222, 24'h333333, 24'h444444);
    send_frame(24'h555555, 24'h666666, 24'h777777, 24'h888888);
    tail_bit();
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL ovf_valid: got %b expected 1", valid_o); end
    checks++; if (data_o !== exp_a) begin errors++; $display("FAIL ovf_held_data: got %h expected %h", data_o, exp_a); end
    checks++; if (ovf_cnt - ov0 != 1) begin errors++; $display("FAIL ovf_pulse: got %0d expected 1", ovf_cnt - ov0); end
    checks++; if (ovf_sticky_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky_set: got %b expected 1", ovf_sticky_o); end
    clr_i = 1'b1;
    wait_clks(1);
    clr_i = 1'b0;
    checks++; if (ovf_sticky_o !== 1'b0) begin errors++; $display("FAIL ovf_sticky_clr: got %b expected 0", ovf_sticky_o); end
    ready_i = 1'b1;
    wait_clks(1);
    ready_i = 1'b0;
    checks++; if (hs_cnt - hs0 != 1) begin errors++; $display("FAIL ovf_hs: got %0d expected 1", hs_cnt - hs0); end
    checks++; if (cap[hs0[5:0]] !== exp_a) begin errors++; $display("FAIL ovf_cap: got %h expected %h", cap[hs0[5:0]], exp_a); end
    stop_stream();
    $display("test_overflow done");
  endtask

  task automatic test_back_to_back();
    logic [FW-1:0] exp_f;
    int hs0, ov0, fe0, idx;
    hs0 = hs_cnt; ov0 = ovf_cnt; fe0 = ferr_cnt;
    ready_i = 1'b1;
    start_stream();
    for (int i = 0; i < 8; i++)
      send_frame(24'h100000 + 24'(i), 24'h200000 + 24'(i), 24'h300000 + 24'(i), 24'hF00000 + 24'(i));
    tail_bit();
    checks++; if (hs_cnt - hs0 != 8) begin errors++; $display("FAIL b2b_hs: got %0d expected 8", hs_cnt - hs0); end
    checks++; if (ovf_cnt - ov0 != 0) begin errors++; $display("FAIL b2b_ovf: got %0d expected 0", ovf_cnt - ov0); end
    checks++; if (ferr_cnt - fe0 != 0) begin errors++; $display("FAIL b2b_ferr: got %0d expected 0", ferr_cnt - fe0); end
    for (int i = 0; i < 8; i++) begin
      exp_f = pack(24'h100000 + 24'(i), 24'h200000 + 24'(i), 24'h300000 + 24'(i), 24'hF00000 + 24'(i));
      idx = hs0 + i;
      checks++; if (cap[idx[5:0]] !== exp_f) begin errors++; $display("FAIL b2b_frame%0d: got %h expected %h", i, cap[idx[5:0]], exp_f); end
    end
    stop_stream();
    ready_i = 1'b0;
    $display("test_back_to_back done");
  endtask

  task automatic test_frame_err();
    logic [FW-1:0] exp_f;
    int hs0, ov0, fe0;
    exp_f = pack(24'hC0FFEE, 24'h0BADF0, 24'h135790, 24'h2468AC);
    hs0 = hs_cnt; ov0 = ovf_cnt; fe0 = ferr_cnt;
    ready_i = 1'b1;
    start_stream();
    send_slot(1'b0, 24'hAAAAAA, 24'h555555, 11);
    send_slot(1'b1, 24'hAAAAAA, 24'h555555, SLOT);
    send_frame(24'hC0FFEE, 24'h0BADF0, 24'h135790, 24'h2468AC);
    tail_bit();
    checks++; if (ferr_cnt - fe0 != 1) begin errors++; $display("FAIL ferr_pulse: got %0d expected 1", ferr_cnt - fe0); end
    checks++; if (hs_cnt - hs0 != 1) begin errors++; $display("FAIL ferr_hs: got %0d expected 1", hs_cnt - hs0); end
    checks++; if (cap[hs0[5:0]] !== exp_f) begin errors++; $display("FAIL ferr_cap: got %h expected %h", cap[hs0[5:0]], exp_f); end
    checks++; if (ovf_cnt - ov0 != 0) begin errors++; $display("FAIL ferr_ovf: got %0d expected 0", ovf_cnt - ov0); end
    stop_stream();
    ready_i = 1'b0;
    $display("test_frame_err done");
  endtask

  task automatic test_enable();
    logic [FW-1:0] exp_f;
    int hs0, fe0;
    exp_f = pack(24'h0A0B0C, 24'hFEDCBA, 24'h010203, 24'h998877);
    hs0 = hs_cnt; fe0 = ferr_cnt;
    ready_i = 1'b1;
    start_stream();
    send_slot(1'b0, 24'h111111, 24'h222222, SLOT);
    send_slot(1'b1, 24'h333333, 24'h444444, 12);
    enable_i = 1'b0;
    wait_clks(4);
    enable_i = 1'b1;
    send_slot(1'b1, '0, '0, 20);
    send_frame(24'h0A0B0C, 24'hFEDCBA, 24'h010203, 24'h998877);
    tail_bit();
    checks++; if (hs_cnt - hs0 != 1) begin errors++; $display("FAIL en_hs: got %0d expected 1", hs_cnt - hs0); end
    checks++; if (cap[hs0[5:0]] !== exp_f) begin errors++; $display("FAIL en_cap: got %h expected %h", cap[hs0[5:0]], exp_f); end
    checks++; if (ferr_cnt - fe0 != 0) begin errors++; $display("FAIL en_ferr: got %0d expected 0", ferr_cnt - fe0); end
    stop_stream();
    ready_i = 1'b0;
    $display("test_enable done");
  endtask

  task automatic test_reset_mid();
    logic [FW-1:0] exp_b;
    int hs0, fe0;
    exp_b = pack(24'h654321, 24'h0FEDCB, 24'h7ABCDE, 24'h876543);
    ready_i = 1'b0;
    start_stream();
    send_frame(24'hDEAD01, 24'hBEEF02, 24'hCAFE03, 24'hF00D04);
    send_slot(1'b0, '0, '0, 12);
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid: got %b expected 1", valid_o); end
    rst_i = 1'b1;
    #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b expected 0", valid_o); end
    checks++; if (data_o !== '0) begin errors++; $display("FAIL rmid_data: got %h expected 0", data_o); end
    wait_clks(2);
    rst_i = 1'b0;
    wait_clks(1);
    hs0 = hs_cnt; fe0 = ferr_cnt;
    ready_i = 1'b1;
    send_slot(1'b0, '0, '0, 20);
    send_slot(1'b1, '0, '0, SLOT);
    send_frame(24'h654321, 24'h0FEDCB, 24'h7ABCDE, 24'h876543);
    tail_bit();
    checks++; if (hs_cnt - hs0 != 1) begin errors++; $display("FAIL rmid_hs: got %0d expected 1", hs_cnt - hs0); end
    checks++; if (cap[hs0[5:0]] !== exp_b) begin errors++; $display("FAIL rmid_cap: got %h expected %h", cap[hs0[5:0]], exp_b); end
    checks++; if (ferr_cnt - fe0 != 0) begin errors++; $display("FAIL rmid_ferr: got %0d expected 0", ferr_cnt - fe0); end
    stop_stream();
    ready_i = 1'b0;
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_frame_err();
    test_enable();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
